// File: rtl/key_matrix_scanner_pkg.sv
// key_matrix_scanner_pkg: shared widths, event type, scan states and column strobe constants.
package key_matrix_scanner_pkg;
  localparam int KEY_W  = 4;
  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int N_KEYS = N_ROWS * N_COLS;
  localparam int CNT_W  = 4;
  typedef struct packed {
    logic [KEY_W-1:0] code;
    logic             press;
  } key_event_t;
  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} scan_state_e;
  localparam logic [N_COLS-1:0] COL_RESET = 4'b1110;
  localparam logic [N_COLS-1:0][N_COLS-1:0] COL_ONEHOT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: first-word-fall-through FIFO that drops pushes when full and flags it stickily.
module key_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW:0] wptr_q, rptr_q;
  logic do_pop, do_push;
  assign empty_o = wptr_q == rptr_q;
  assign full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign do_pop  = pop_i && !empty_o;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      mem_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      if (push_i && !do_push) overflow_o <= 1'b1;
    end
endmodule

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: strobes a 4x4 key matrix, debounces each key and queues press/release events.
module key_matrix_scanner
  import key_matrix_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 10000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  output logic [N_COLS-1:0] colOut,
  input  logic [N_ROWS-1:0] rowIn,
  output logic              keyValid,
  input  logic              keyReady,
  output logic [KEY_W-1:0]  keyCode,
  output logic              keyPress,
  output logic              overflow
);
  localparam int PW = $clog2(SCAN_DIV + 1);
  logic [N_ROWS-1:0] rs1_q, rs2_q, row_snap_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0] col_q, col_snap_q, row_k;
  scan_state_e state_q, state_d;
  logic tick, proc, raw, hit, push, empty, full;
  logic [KEY_W-1:0] key_n;
  logic [N_KEYS-1:0] deb_q;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt_q;
  key_event_t ev, head;
  assign tick    = presc_q == PW'(SCAN_DIV);
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign colOut  = COL_ONEHOT[col_q];
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      rs1_q      <= '1;
      rs2_q      <= '1;
      presc_q    <= '0;
      col_q      <= '0;
      col_snap_q <= '0;
      row_snap_q <= '1;
    end else begin
      rs1_q   <= rowIn;
      rs2_q   <= rs1_q;
      presc_q <= presc_d;
      if (tick) begin
        col_q      <= col_q + 1'b1;
        col_snap_q <= col_q;
        row_snap_q <= rs2_q;
      end
    end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (tick ? S0 : IDLE) :
              state_q == S3   ? IDLE : scan_state_e'(state_q + 3'd1);
  always_comb begin
    proc  = state_q != IDLE;
    row_k = 2'(state_q - 3'd1);
  end
  // one key of the snapped column per state; a mismatch must persist DEBOUNCE_SCANS samples
  assign key_n = {col_snap_q, row_k};
  assign raw   = ~row_snap_q[row_k];
  assign hit   = raw != deb_q[key_n] && cnt_q[key_n] == CNT_W'(DEBOUNCE_SCANS - 1);
  assign push  = proc && hit;
  assign ev    = '{code: key_n, press: raw};
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else if (proc) begin
      cnt_q[key_n] <= (raw == deb_q[key_n] || hit) ? '0 : cnt_q[key_n] + 1'b1;
      if (hit) deb_q[key_n] <= raw;
    end
  key_event_fifo #(.WIDTH($bits(key_event_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .push_i    (push),
    .wdata_i   (ev),
    .pop_i     (keyReady),
    .rdata_o   (head),
    .full_o    (full),
    .empty_o   (empty),
    .overflow_o(overflow)
  );
  assign keyValid = !empty;
  assign keyCode  = head.code;
  assign keyPress = head.press;
endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: directed checks of scan timing, debounce, FIFO overflow and reset.
module tb_key_matrix_scanner;
  import key_matrix_scanner_pkg::*;
  logic CLK = 1'b0, RSTn = 1'b0, keyReady = 1'b1;
  logic [3:0] colOut, rowIn, keyCode;
  logic keyValid, keyPress, overflow;
  logic [15:0] held = '0;
  logic [4:0] evq[$];
  int n_chk = 0, n_fail = 0;
  key_matrix_scanner #(.SCAN_DIV(9), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RSTn(RSTn), .colOut(colOut), .rowIn(rowIn), .keyValid(keyValid),
    .keyReady(keyReady), .keyCode(keyCode), .keyPress(keyPress), .overflow(overflow)
  );
  always #5 CLK = ~CLK;
  // a held key pulls its row low while its column is strobed
  always_comb begin
    rowIn = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!colOut[c])
        for (int r = 0; r < 4; r++) if (held[c*4+r]) rowIn[r] = 1'b0;
  end
  always @(negedge CLK) if (RSTn && keyValid && keyReady) evq.push_back({keyCode, keyPress});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic step(input string tag, input logic [3:0] exp_col);
    logic [3:0] prev = colOut;
    int n = 0;
    while (colOut == prev && n < 50) begin
      cyc(1);
      n++;
    end
    check({tag, "_period"}, n, 10);
    check({tag, "_col"}, colOut, exp_col);
  endtask
  function automatic logic [31:0] ev_at(input int i);
    return i < evq.size() ? {27'd0, evq[i]} : 32'hDEAD;
  endfunction
  initial begin
    int found;
    cyc(3);
    check("rst_col", colOut, 4'b1110);
    check("rst_valid", keyValid, 0);
    check("rst_code", keyCode, 0);
    check("rst_press", keyPress, 0);
    check("rst_ovf", overflow, 0);
    RSTn = 1'b1;
    step("scan1", 4'b1101);
    step("scan2", 4'b1011);
    step("scan3", 4'b0111);
    step("scan0", 4'b1110);
    check("idle_events", evq.size(), 0);
    check("idle_valid", keyValid, 0);
    held[6] = 1'b1;
    cyc(200);
    check("press6_n", evq.size(), 1);
    check("press6_ev", ev_at(0), {4'd6, 1'b1});
    cyc(160);
    check("press6_hold_n", evq.size(), 1);
    evq.delete();
    held[6] = 1'b0;
    cyc(200);
    check("rel6_n", evq.size(), 1);
    check("rel6_ev", ev_at(0), {4'd6, 1'b0});
    evq.delete();
    for (int i = 0; i < 8; i++) begin
      held[6] = ~i[0];
      cyc(40);
    end
    held[6] = 1'b0;
    cyc(120);
    check("bounce_n", evq.size(), 0);
    keyReady = 1'b0;
    held[4:0] = 5'h1F;
    cyc(200);
    check("ovf_valid", keyValid, 1);
    check("ovf_head", {keyCode, keyPress}, {4'd0, 1'b1});
    check("ovf_flag", overflow, 1);
    evq.delete();
    keyReady = 1'b1;
    cyc(20);
    check("drain_n", evq.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("drain_ev%0d", i), ev_at(i), {4'(i), 1'b1});
    check("drain_ovf", overflow, 1);
    check("drain_valid", keyValid, 0);
    keyReady = 1'b0;
    held[1:0] = 2'b00;
    cyc(200);
    check("pend_valid", keyValid, 1);
    check("pend_head", {keyCode, keyPress}, {4'd0, 1'b0});
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      cyc(1);
      if (dut.state_q == S2) found = 1;
    end
    check("wait_s2", found, 1);
    RSTn = 1'b0;
    #1;
    check("mrst_valid", keyValid, 0);
    check("mrst_col", colOut, 4'b1110);
    check("mrst_ovf", overflow, 0);
    check("mrst_code", keyCode, 0);
    cyc(3);
    evq.delete();
    keyReady = 1'b1;
    RSTn = 1'b1;
    cyc(200);
    check("rerep_n", evq.size(), 3);
    check("rerep_ev0", ev_at(0), {4'd2, 1'b1});
    check("rerep_ev1", ev_at(1), {4'd3, 1'b1});
    check("rerep_ev2", ev_at(2), {4'd4, 1'b1});
    check("rerep_ovf", overflow, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
